// File: rtl/pe_sequencer_if.sv
// Handshake and PE-control bundle between the PE sequencer (slave) and its
// surroundings: job control, weight/activation streams, PE port and psum output.
interface pe_sequencer_if #(
    parameter int DATA_SIZE    = 8,
    parameter int MAC_RES_SIZE = 2 * DATA_SIZE + 4
);
    logic                    go_i;
    logic [7:0]              cfg_wcount_i;
    logic [7:0]              cfg_acount_i;
    logic [DATA_SIZE-1:0]    w_data_i;
    logic                    w_valid_i;
    logic                    w_ready_o;
    logic [DATA_SIZE-1:0]    a_data_i;
    logic                    a_valid_i;
    logic                    a_ready_o;
    logic [DATA_SIZE-1:0]    pe_weights_o;
    logic [DATA_SIZE-1:0]    pe_acts_o;
    logic [MAC_RES_SIZE-1:0] pe_psum_o;
    logic                    pe_loadw_o;
    logic                    pe_loada_o;
    logic                    pe_start_o;
    logic                    pe_sums_o;
    logic [MAC_RES_SIZE-1:0] pe_psum_i;
    logic                    pe_psum_valid_i;
    logic                    pe_done_i;
    logic [MAC_RES_SIZE-1:0] psum_data_o;
    logic                    psum_valid_o;
    logic                    busy_o;
    logic                    done_o;
    logic                    err_cfg_o;

    modport master (
        output go_i, cfg_wcount_i, cfg_acount_i,
        output w_data_i, w_valid_i, a_data_i, a_valid_i,
        output pe_psum_i, pe_psum_valid_i, pe_done_i,
        input  w_ready_o, a_ready_o,
        input  pe_weights_o, pe_acts_o, pe_psum_o,
        input  pe_loadw_o, pe_loada_o, pe_start_o, pe_sums_o,
        input  psum_data_o, psum_valid_o, busy_o, done_o, err_cfg_o
    );

    modport slave (
        input  go_i, cfg_wcount_i, cfg_acount_i,
        input  w_data_i, w_valid_i, a_data_i, a_valid_i,
        input  pe_psum_i, pe_psum_valid_i, pe_done_i,
        output w_ready_o, a_ready_o,
        output pe_weights_o, pe_acts_o, pe_psum_o,
        output pe_loadw_o, pe_loada_o, pe_start_o, pe_sums_o,
        output psum_data_o, psum_valid_o, busy_o, done_o, err_cfg_o
    );
endinterface

// File: rtl/pe_sequencer.sv
// Job sequencer for one systolic PE: buffers a kernel and an activation row,
// bursts them into the PE scratchpads, triggers compute and collects the psums.
module pe_sequencer #(
    parameter int DATA_SIZE       = 8,
    parameter int RF_NUM_REGISTER = 16,
    parameter int MAC_RES_SIZE    = 2 * DATA_SIZE + 4
) (
    input  logic          clk,
    input  logic          nrst,
    pe_sequencer_if.slave bus
);
    localparam int         IDX_W  = (RF_NUM_REGISTER > 1) ? $clog2(RF_NUM_REGISTER) : 1;
    localparam logic [7:0] RF_MAX = 8'(RF_NUM_REGISTER);

    localparam logic [3:0] IDLE    = 4'd0;
    localparam logic [3:0] FILL    = 4'd1;
    localparam logic [3:0] BURST_W = 4'd2;
    localparam logic [3:0] BURST_A = 4'd3;
    localparam logic [3:0] GAP     = 4'd4;
    localparam logic [3:0] START   = 4'd5;
    localparam logic [3:0] COMPUTE = 4'd6;
    localparam logic [3:0] SUMS    = 4'd7;
    localparam logic [3:0] FINISH  = 4'd8;

    logic [3:0]              state;
    logic                    go_q;
    logic [7:0]              wcount;
    logic [7:0]              acount;
    logic [7:0]              w_cnt;
    logic [7:0]              a_cnt;
    logic [7:0]              idx;
    logic [DATA_SIZE-1:0]    w_buf [RF_NUM_REGISTER];
    logic [DATA_SIZE-1:0]    a_buf [RF_NUM_REGISTER];
    logic [MAC_RES_SIZE-1:0] psum_data;
    logic                    psum_valid;
    logic                    err_cfg;

    logic       w_ready;
    logic       a_ready;
    logic       w_fire;
    logic       a_fire;
    logic       go_edge;
    logic       cfg_ok;
    logic       fill_done;
    logic [7:0] w_cnt_nxt;
    logic [7:0] a_cnt_nxt;

    // Ready is a pure function of the fill counters, so it drops the moment a count is met.
    assign w_ready   = (state == FILL) && (w_cnt != wcount);
    assign a_ready   = (state == FILL) && (a_cnt != acount);
    assign w_fire    = bus.w_valid_i && w_ready;
    assign a_fire    = bus.a_valid_i && a_ready;
    assign w_cnt_nxt = w_cnt + {7'd0, w_fire};
    assign a_cnt_nxt = a_cnt + {7'd0, a_fire};
    assign fill_done = (w_cnt_nxt == wcount) && (a_cnt_nxt == acount);

    // A go held high across a whole job must not relaunch it, so only the rising edge counts.
    assign go_edge = bus.go_i && !go_q;
    assign cfg_ok  = (bus.cfg_wcount_i != 8'd0) && (bus.cfg_wcount_i <= RF_MAX) &&
                     (bus.cfg_wcount_i <= bus.cfg_acount_i) && (bus.cfg_acount_i <= RF_MAX);

    // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state   <= IDLE;
            go_q    <= 1'b0;
            wcount  <= 8'd0;
            acount  <= 8'd0;
            w_cnt   <= 8'd0;
            a_cnt   <= 8'd0;
            idx     <= 8'd0;
            err_cfg <= 1'b0;
        end else begin
            go_q    <= bus.go_i;
            err_cfg <= 1'b0;
            case (state)
                IDLE: begin
                    if (go_edge) begin
                        if (cfg_ok) begin
                            wcount <= bus.cfg_wcount_i;
                            acount <= bus.cfg_acount_i;
                            w_cnt  <= 8'd0;
                            a_cnt  <= 8'd0;
                            state  <= FILL;
                        end else begin
                            err_cfg <= 1'b1;
                        end
                    end
                end
                FILL: begin
                    w_cnt <= w_cnt_nxt;
                    a_cnt <= a_cnt_nxt;
                    if (fill_done) begin
                        idx   <= 8'd0;
                        state <= BURST_W;
                    end
                end
                BURST_W: begin
                    if (idx == wcount - 8'd1) begin
                        idx   <= 8'd0;
                        state <= BURST_A;
                    end else begin
                        idx <= idx + 8'd1;
                    end
                end
                BURST_A: begin
                    if (idx == acount - 8'd1) begin
                        idx   <= 8'd0;
                        state <= GAP;
                    end else begin
                        idx <= idx + 8'd1;
                    end
                end
                GAP:     state <= START;
                START:   state <= COMPUTE;
                COMPUTE: if (bus.pe_done_i) state <= SUMS;
                SUMS:    if (bus.pe_done_i && bus.pe_psum_valid_i) state <= FINISH;
                FINISH:  state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            psum_valid <= 1'b0;
            psum_data  <= '0;
        end else begin
            psum_valid <= (state == SUMS) && bus.pe_psum_valid_i;
            if ((state == SUMS) && bus.pe_psum_valid_i) psum_data <= bus.pe_psum_i;
        end
    end

    // NOTE: buffers have no reset; pointers restart every job and PE data outputs are gated to 0.
    always_ff @(posedge clk) begin
        if (w_fire) w_buf[w_cnt[IDX_W-1:0]] <= bus.w_data_i;
        if (a_fire) a_buf[a_cnt[IDX_W-1:0]] <= bus.a_data_i;
    end

    assign bus.w_ready_o    = w_ready;
    assign bus.a_ready_o    = a_ready;
    assign bus.pe_loadw_o   = (state == BURST_W);
    assign bus.pe_loada_o   = (state == BURST_A);
    assign bus.pe_start_o   = (state == START);
    assign bus.pe_sums_o    = (state == SUMS);
    assign bus.pe_weights_o = (state == BURST_W) ? w_buf[idx[IDX_W-1:0]] : '0;
    assign bus.pe_acts_o    = (state == BURST_A) ? a_buf[idx[IDX_W-1:0]] : '0;
    assign bus.pe_psum_o    = '0;
    assign bus.psum_data_o  = psum_data;
    assign bus.psum_valid_o = psum_valid;
    assign bus.busy_o       = (state != IDLE);
    assign bus.done_o       = (state == FINISH);
    assign bus.err_cfg_o    = err_cfg;
endmodule

// File: tb/tb_pe_sequencer.sv
// Directed bench for pe_sequencer: table of job configurations plus hand-written
// sequences for held go, go while busy and reset during SUMS, with a behavioral PE.
module tb_pe_sequencer;
    localparam int DS  = 8;
    localparam int RF  = 16;
    localparam int MRS = 2 * DS + 4;

    logic clk  = 1'b0;
    logic nrst = 1'b0;
    always #5 clk = ~clk;

    pe_sequencer_if #(.DATA_SIZE(DS), .MAC_RES_SIZE(MRS)) bus ();

    pe_sequencer #(.DATA_SIZE(DS), .RF_NUM_REGISTER(RF), .MAC_RES_SIZE(MRS)) dut (
        .clk  (clk),
        .nrst (nrst),
        .bus  (bus)
    );

    typedef struct {
        int w;
        int a;
        bit stall;
        bit err;
    } vec_t;

    int checks   = 0;
    int failures = 0;

    logic [DS-1:0] w_src [32];
    logic [DS-1:0] a_src [32];
    bit stream_en;
    bit stall;
    int w_ptr, a_ptr, w_fires, a_fires;
    bit w_pend, a_pend;

    logic [DS-1:0] pe_w [RF];
    logic [DS-1:0] pe_a [RF];
    int pe_wa, pe_aa, pe_nw, pe_na, pe_comp, pe_out;

    int cyc;
    int loadw_n, loada_n, first_w, last_w, first_a, last_a, start_n, start_cyc;
    int data_err, done_n, err_n, busy_n, ready_n;
    int psums [$];

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic int exp_psum(input int k, input int nw);
        int s = 0;
        for (int j = 0; j < nw; j++) s += int'(w_src[j]) * int'(a_src[k + j]);
        return s;
    endfunction

    function automatic int pe_conv(input int k);
        int s = 0;
        for (int j = 0; j < pe_nw; j++) s += int'(pe_w[j]) * int'(pe_a[k + j]);
        return s;
    endfunction

    function automatic int get_psum(input int i);
        if (i < psums.size()) return psums[i];
        return -1;
    endfunction

    function automatic bit outputs_nonzero();
        return bus.w_ready_o || bus.a_ready_o || (bus.pe_weights_o != 0) || (bus.pe_acts_o != 0) ||
               (bus.pe_psum_o != 0) || bus.pe_loadw_o || bus.pe_loada_o || bus.pe_start_o ||
               bus.pe_sums_o || (bus.psum_data_o != 0) || bus.psum_valid_o || bus.busy_o ||
               bus.done_o || bus.err_cfg_o;
    endfunction

    // Monitor, behavioral PE and stream sources share one negedge process so ordering is fixed.
    initial begin
        forever begin
            @(negedge clk);
            cyc++;
            if (!nrst) begin
                w_pend = 1'b0;
                a_pend = 1'b0;
                pe_wa = 0; pe_aa = 0; pe_comp = 0; pe_out = 0;
                bus.pe_done_i = 1'b0;
                bus.pe_psum_valid_i = 1'b0;
                bus.pe_psum_i = '0;
                bus.w_valid_i = 1'b0;
                bus.a_valid_i = 1'b0;
            end else begin
                if (bus.pe_loadw_o) begin
                    if (first_w < 0) first_w = cyc;
                    last_w = cyc;
                    if (loadw_n >= 32 || bus.pe_weights_o != w_src[loadw_n]) data_err++;
                    loadw_n++;
                end else if (bus.pe_weights_o != 0) data_err++;
                if (bus.pe_loada_o) begin
                    if (first_a < 0) first_a = cyc;
                    last_a = cyc;
                    if (loada_n >= 32 || bus.pe_acts_o != a_src[loada_n]) data_err++;
                    loada_n++;
                end else if (bus.pe_acts_o != 0) data_err++;
                if (bus.pe_start_o) begin start_n++; start_cyc = cyc; end
                if (bus.psum_valid_o) psums.push_back(int'(bus.psum_data_o));
                if (bus.done_o) done_n++;
                if (bus.err_cfg_o) err_n++;
                if (bus.busy_o) busy_n++;
                if (bus.w_ready_o || bus.a_ready_o) ready_n++;

                if (bus.pe_loadw_o && pe_wa < RF) begin pe_w[pe_wa] = bus.pe_weights_o; pe_wa++; end
                if (bus.pe_loada_o && pe_aa < RF) begin pe_a[pe_aa] = bus.pe_acts_o; pe_aa++; end
                bus.pe_done_i = 1'b0;
                bus.pe_psum_valid_i = 1'b0;
                if (bus.pe_start_o) begin
                    pe_nw = pe_wa; pe_na = pe_aa; pe_wa = 0; pe_aa = 0; pe_comp = 2; pe_out = 0;
                end else if (pe_comp > 0) begin
                    pe_comp--;
                    if (pe_comp == 0) bus.pe_done_i = 1'b1;
                end else if (bus.pe_sums_o && pe_out <= pe_na - pe_nw) begin
                    bus.pe_psum_i = MRS'(pe_conv(pe_out));
                    bus.pe_psum_valid_i = 1'b1;
                    bus.pe_done_i = (pe_out == pe_na - pe_nw);
                    pe_out++;
                end

                if (w_pend) begin w_ptr++; w_fires++; end
                if (a_pend) begin a_ptr++; a_fires++; end
                bus.w_valid_i = stream_en && (!stall || $urandom_range(0, 1) == 1);
                bus.a_valid_i = stream_en && (!stall || $urandom_range(0, 1) == 1);
                bus.w_data_i  = (w_ptr < 32) ? w_src[w_ptr] : '0;
                bus.a_data_i  = (a_ptr < 32) ? a_src[a_ptr] : '0;
                w_pend = bus.w_valid_i && bus.w_ready_o;
                a_pend = bus.a_valid_i && bus.a_ready_o;
            end
        end
    end

    task automatic step(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic clear_stats();
        loadw_n = 0; loada_n = 0; first_w = -1; last_w = -1; first_a = -1; last_a = -1;
        start_n = 0; start_cyc = -1; data_err = 0; done_n = 0; err_n = 0; busy_n = 0; ready_n = 0;
        w_ptr = 0; a_ptr = 0; w_fires = 0; a_fires = 0;
        psums.delete();
    endtask

    task automatic start_job(input int w, input int a, input bit st);
        clear_stats();
        stall = st;
        bus.cfg_wcount_i = 8'(w);
        bus.cfg_acount_i = 8'(a);
        stream_en = 1'b1;
        bus.go_i = 1'b1;
        step(1);
        bus.go_i = 1'b0;
    endtask

    task automatic wait_done(input int budget, input bit extra_go);
        for (int i = 0; i < budget && done_n == 0; i++) begin
            if (extra_go && i == 4) begin
                bus.go_i = 1'b1;
                bus.cfg_wcount_i = 8'd0;
            end else if (extra_go && i == 5) begin
                bus.go_i = 1'b0;
            end
            step(1);
        end
        if (extra_go) bus.go_i = 1'b0;
        step(2);
        stream_en = 1'b0;
    endtask

    task automatic check_job(input string tag, input int w, input int a);
        check({tag, " done_pulses"}, done_n, 1);
        check({tag, " err_pulses"}, err_n, 0);
        check({tag, " w_accepted"}, w_fires, w);
        check({tag, " a_accepted"}, a_fires, a);
        check({tag, " loadw_cycles"}, loadw_n, w);
        check({tag, " loadw_contiguous"}, last_w - first_w + 1, w);
        check({tag, " loada_after_loadw"}, first_a, last_w + 1);
        check({tag, " loada_cycles"}, loada_n, a);
        check({tag, " loada_contiguous"}, last_a - first_a + 1, a);
        check({tag, " start_cycles"}, start_n, 1);
        check({tag, " start_after_gap"}, start_cyc, last_a + 2);
        check({tag, " pe_data_errors"}, data_err, 0);
        check({tag, " psum_count"}, psums.size(), a - w + 1);
        for (int k = 0; k <= a - w; k++)
            check($sformatf("%s psum[%0d]", tag, k), get_psum(k), exp_psum(k, w));
    endtask

    vec_t vecs [9];

    initial begin
        vecs = '{
            '{3, 5, 1'b0, 1'b0},
            '{3, 5, 1'b1, 1'b0},
            '{16, 16, 1'b0, 1'b0},
            '{1, 16, 1'b0, 1'b0},
            '{4, 4, 1'b1, 1'b0},
            '{0, 5, 1'b0, 1'b1},
            '{4, 3, 1'b0, 1'b1},
            '{2, 17, 1'b0, 1'b1},
            '{17, 17, 1'b0, 1'b1}
        };
        for (int i = 0; i < 32; i++) begin
            w_src[i] = (i < RF) ? DS'(i + 1) : 8'hEE;
            a_src[i] = (i < RF) ? DS'(i + 1) : 8'hDD;
        end
        stream_en = 1'b0;
        stall = 1'b0;
        bus.go_i = 1'b0;
        bus.cfg_wcount_i = 8'd0;
        bus.cfg_acount_i = 8'd0;
        bus.w_data_i = '0;
        bus.a_data_i = '0;
        bus.w_valid_i = 1'b0;
        bus.a_valid_i = 1'b0;
        bus.pe_psum_i = '0;
        bus.pe_psum_valid_i = 1'b0;
        bus.pe_done_i = 1'b0;
        clear_stats();

        step(3);
        check("reset outputs_nonzero", outputs_nonzero(), 0);
        nrst = 1'b1;
        step(2);
        check("idle outputs_nonzero", outputs_nonzero(), 0);

        for (int i = 0; i < 9; i++) begin
            string tag = $sformatf("vec%0d(w=%0d,a=%0d)", i, vecs[i].w, vecs[i].a);
            start_job(vecs[i].w, vecs[i].a, vecs[i].stall);
            if (vecs[i].err) begin
                step(6);
                stream_en = 1'b0;
                check({tag, " err_pulses"}, err_n, 1);
                check({tag, " busy_cycles"}, busy_n, 0);
                check({tag, " ready_cycles"}, ready_n, 0);
                check({tag, " done_pulses"}, done_n, 0);
            end else begin
                wait_done(400, 1'b0);
                check_job(tag, vecs[i].w, vecs[i].a);
            end
            if (i == 0) begin
                check("basic psum0", get_psum(0), 14);
                check("basic psum1", get_psum(1), 20);
                check("basic psum2", get_psum(2), 26);
            end
            if (i == 2) check("full psum0", get_psum(0), 1496);
            step(2);
        end

        // Bad config with go held high: exactly one error pulse.
        clear_stats();
        bus.cfg_wcount_i = 8'd0;
        bus.cfg_acount_i = 8'd5;
        bus.go_i = 1'b1;
        step(4);
        bus.go_i = 1'b0;
        step(3);
        check("held_go_bad err_pulses", err_n, 1);
        check("held_go_bad busy_cycles", busy_n, 0);

        // Good config with go held through the whole job: no relaunch afterwards.
        clear_stats();
        stall = 1'b0;
        bus.cfg_wcount_i = 8'd2;
        bus.cfg_acount_i = 8'd3;
        stream_en = 1'b1;
        bus.go_i = 1'b1;
        wait_done(200, 1'b0);
        check_job("held_go", 2, 3);
        step(5);
        check("held_go no_restart busy", bus.busy_o, 0);
        check("held_go no_restart done", done_n, 1);
        bus.go_i = 1'b0;
        step(2);

        // go pulsed mid-job with an invalid config must be ignored.
        start_job(3, 5, 1'b0);
        wait_done(200, 1'b1);
        check_job("go_busy", 3, 5);
        step(4);
        check("go_busy idle_after", bus.busy_o, 0);

        // Reset asserted during SUMS, then a fresh job.
        start_job(3, 5, 1'b0);
        for (int i = 0; i < 200 && !bus.pe_sums_o; i++) step(1);
        check("midreset reached_sums", bus.pe_sums_o, 1);
        stream_en = 1'b0;
        nrst = 1'b0;
        #1;
        check("midreset outputs_nonzero", outputs_nonzero(), 0);
        step(2);
        check("midreset held outputs_nonzero", outputs_nonzero(), 0);
        nrst = 1'b1;
        step(2);
        start_job(3, 5, 1'b0);
        wait_done(200, 1'b0);
        check_job("after_reset", 3, 5);
        check("after_reset psum0", get_psum(0), 14);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/pe_sequencer.md
PE_SEQUENCER -- requirements
Module: pe_sequencer

Interface
REQ-001 The block SHALL have parameter DATA_SIZE, default 8, meaning weight/activation width.
REQ-002 The block SHALL have parameter RF_NUM_REGISTER, default 16, meaning PE scratchpad depth and internal buffer depth.
REQ-003 The block SHALL have parameter MAC_RES_SIZE, default 2*DATA_SIZE+4, meaning psum width.
REQ-004 The block SHALL have ports, in order:
- clk  in  1  clock, rising edge.
- nrst  in  1  reset, asynchronous, active-low.
- go_i  in  1  start job, pulse.
- cfg_wcount_i  in  8  kernel length.
- cfg_acount_i  in  8  activation length.
- w_data_i  in  DATA_SIZE  weight stream data.
- w_valid_i  in  1  weight stream valid.
- w_ready_o  out  1  weight stream ready.
- a_data_i  in  DATA_SIZE  activation stream data.
- a_valid_i  in  1  activation stream valid.
- a_ready_o  out  1  activation stream ready.
- pe_weights_o  out  DATA_SIZE  weight to PE.
- pe_acts_o  out  DATA_SIZE  activation to PE.
- pe_psum_o  out  MAC_RES_SIZE  psum chain input to PE, constant 0.
- pe_loadw_o  out  1  PE weight write.
- pe_loada_o  out  1  PE activation write.
- pe_start_o  out  1  PE compute start.
- pe_sums_o  out  1  PE systolic sum enable.
- pe_psum_i  in  MAC_RES_SIZE  PE psum output.
- pe_psum_valid_i  in  1  PE psum valid.
- pe_done_i  in  1  PE done flag.
- psum_data_o  out  MAC_RES_SIZE  collected psum.
- psum_valid_o  out  1  psum_data_o valid; no backpressure.
- busy_o  out  1  job in progress.
- done_o  out  1  job complete, one-cycle pulse.
- err_cfg_o  out  1  config rejected, one-cycle pulse.

Function
REQ-005 The block SHALL implement states IDLE, FILL, BURST_W, BURST_A, GAP, START, COMPUTE, SUMS, FINISH.
REQ-006 In IDLE, go_i=1 SHALL latch the config and enter FILL if 1<=wcount<=RF_NUM_REGISTER and wcount<=acount<=RF_NUM_REGISTER; otherwise it SHALL pulse err_cfg_o and remain in IDLE.
REQ-007 In IDLE, go_i SHALL be ignored while high for longer than one cycle after acceptance; it SHALL also be ignored in every state other than IDLE.
REQ-008 In FILL, the block SHALL accept exactly wcount weights and acount activations into internal buffers using valid&&ready handshakes; the two streams are independent and may complete in any order or simultaneously.
REQ-009 Each ready SHALL deassert in the same cycle its count is reached; no element beyond the count SHALL be accepted.
REQ-010 FILL SHALL exit to BURST_W on the cycle after both counts are reached.
REQ-011 BURST_W SHALL assert pe_loadw_o for exactly wcount consecutive cycles, presenting buffer entries 0..wcount-1 in order; BURST_A SHALL then do the same with pe_loada_o for acount cycles.
REQ-012 The load enables SHALL never drop mid-burst.
REQ-013 GAP SHALL be one cycle with all pe_* controls low, so that the PE resets its scratchpad addresses to 0.
REQ-014 START SHALL assert pe_start_o for exactly one cycle, then enter COMPUTE.
REQ-015 COMPUTE SHALL hold all pe_* controls low until pe_done_i=1, then enter SUMS.
REQ-016 SUMS SHALL assert pe_sums_o continuously.
REQ-017 On every SUMS cycle with pe_psum_valid_i=1, the block SHALL register pe_psum_i to psum_data_o and assert psum_valid_o one cycle later.
REQ-018 When pe_done_i=1 and pe_psum_valid_i=1 in SUMS, the block SHALL deassert pe_sums_o on the next cycle and enter FINISH.
REQ-019 FINISH SHALL pulse done_o for one cycle and return to IDLE.
REQ-020 The block SHALL emit exactly acount-wcount+1 psums per job.
REQ-021 busy_o SHALL be 1 in every state except IDLE.
REQ-022 pe_weights_o and pe_acts_o SHALL be 0 whenever the corresponding load enable is low.

Reset
REQ-023 nrst=0 SHALL asynchronously force state IDLE and clear counters and buffer pointers.
REQ-024 nrst=0 SHALL force every output to 0, including a reset asserted mid-job; buffer contents need not be cleared.
REQ-025 After reset release, the first go_i SHALL start a fresh job.

Verification
REQ-026 The bench SHALL cover each of the following directed scenarios:
- Basic job: wcount=3, acount=5, weights 1,2,3, acts 1..5, both streams always valid, behavioral PE model -> loadw high 3 cycles, loada high 5 cycles, one GAP cycle, one start cycle, psums 14,20,26 in order, then one done_o pulse.
- Random stalls: w_valid_i/a_valid_i toggled randomly -> identical PE load sequence and psums as the basic job; ready never exceeds the counts.
- Boundary: wcount=acount=16 -> one psum; wcount=1, acount=16 -> 16 psums.
- Config errors: wcount=0, acount<wcount, or acount=17 -> err_cfg_o pulse, busy_o stays 0, no ready asserted.
- Mid-job reset: nrst low during SUMS -> all outputs 0 immediately; next job runs correctly.
- go_i pulsed while busy -> ignored, and the current job completes unaffected.
